// File: rtl/booth_multiplier_seq.sv
// Sequential Booth multiplier: one Booth step per cycle, start/done handshake, signed or unsigned operands.
// Latency N+1 cycles from start to done; start is ignored while running. Radix-4 recoding when BOOTH_RADIX4_EN is defined.
module booth_multiplier_seq #(
    parameter int width = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [width-1:0]     A,
    input  logic [width-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*width-1:0]   S
);

    localparam int AW = width + 2;
`ifdef BOOTH_RADIX4_EN
    localparam int SH = 2;
    localparam int QW = ((width + 2) / 2) * 2;
    localparam int N  = QW / 2;
`else
    localparam int SH = 1;
    localparam int QW = width + 1;
    localparam int N  = width + 1;
`endif
    localparam int CW = $clog2(N + 1);
    localparam int TW = AW + QW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   m;
    logic        [QW-1:0]   q;
    logic                   qm1;
    logic        [CW-1:0]   cnt;

    logic signed [AW-1:0]   sum;
    logic signed [TW-1:0]   shv;

    function automatic logic [AW-1:0] ext_m(input logic s, input logic [width-1:0] a);
        return {{(AW-width){s & a[width-1]}}, a};
    endfunction

    function automatic logic [QW-1:0] ext_q(input logic s, input logic [width-1:0] b);
        return {{(QW-width){s & b[width-1]}}, b};
    endfunction

    always_comb begin
        sum = acc;
`ifdef BOOTH_RADIX4_EN
        case ({q[1:0], qm1})
            3'b001, 3'b010: sum = acc + m;
            3'b011:         sum = acc + (m <<< 1);
            3'b100:         sum = acc - (m <<< 1);
            3'b101, 3'b110: sum = acc - m;
            default:        sum = acc;
        endcase
`else
        case ({q[0], qm1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
`endif
        shv = $signed({sum, q, qm1}) >>> SH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= CW'(N);
                        m     <= ext_m(tc, A);
                        q     <= ext_q(tc, B);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    {acc, q, qm1} <= shv;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    // Product occupies the low bits of {acc, q} after the final shift.
                    S    <= {acc[2*width-QW-1:0], q};
                    done <= 1'b1;
                    if (start) begin
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= CW'(N);
                        m     <= ext_m(tc, A);
                        q     <= ext_q(tc, B);
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Randomized and directed bench for booth_multiplier_seq against an arithmetic product model.
module tb_booth_multiplier_seq;

    localparam int W = 9;
`ifdef BOOTH_RADIX4_EN
    localparam int N = (W + 2) / 2;
`else
    localparam int N = W + 1;
`endif
    localparam int TMO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             tc;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   S;

    int n_checks = 0;
    int n_fail   = 0;

    booth_multiplier_seq #(.width(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .tc    (tc),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic t, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, p;
        x = t ? longint'($signed(a)) : longint'(a);
        y = t ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[2*W-1:0];
    endfunction

    // Issue one op from an idle DUT; returns the product, cycles to done, and busy after edge 0.
    task automatic do_op(input logic t, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] s, output int lat, output logic b0);
        start = 1'b1; tc = t; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
        b0 = busy;
        tc = $urandom_range(0, 1); A = W'($urandom); B = W'($urandom);
        lat = 0;
        while (lat < TMO && !done) begin
            @(posedge clk); #1;
            lat++;
        end
        s = S;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tc = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b S=%h required 0 0 0", busy, done, S);
        end
        start = 1'b1; A = 9'd5; B = 9'd5;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_start: busy=%b required 0", busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2*W-1:0] s;
        int lat;
        logic b0;
        logic        t_v[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] a_v[5] = '{9'h100, 9'h100, 9'h1FF, 9'h1FF, 9'h000};
        logic [W-1:0] b_v[5] = '{9'h100, 9'h0FF, 9'h1FF, 9'h1FF, 9'h1FF};
        logic [2*W-1:0] e_v[5] = '{18'h10000, 18'h30100, 18'h3FC01, 18'h00001, 18'h00000};
        for (int i = 0; i < 5; i++) begin
            do_op(t_v[i], a_v[i], b_v[i], s, lat, b0);
            n_checks++;
            if (s !== e_v[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: S=%h required %h", i, s, e_v[i]);
            end
            n_checks++;
            if (lat != N + 1 || b0 !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_lat_%0d: latency=%0d busy0=%b required %0d 1", i, lat, b0, N + 1);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_pulse_%0d: done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        logic [2*W-1:0] s1 = '0;
        start = 1'b1; tc = 1'b0; A = 9'd3; B = 9'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        if (done) begin ndone++; s1 = S; end
        start = 1'b1; A = 9'd7; B = 9'd7;
        @(posedge clk); #1;
        if (done) begin ndone++; s1 = S; end
        start = 1'b0;
        for (int c = 0; c < 3 * (N + 1); c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (ndone == 0) s1 = S;
                ndone++;
            end
        end
        n_checks++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL start_ignored_count: dones=%0d required 1", ndone);
        end
        n_checks++;
        if (s1 !== 18'd15) begin
            n_fail++;
            $display("FAIL start_ignored_S: S=%h required %h", s1, 18'd15);
        end
    endtask

    task automatic test_back_to_back();
        int c1 = 0, c2 = 0;
        logic [2*W-1:0] s1, s2;
        start = 1'b1; tc = 1'b1; A = 9'd4; B = 9'd4;
        @(posedge clk); #1;
        A = 9'd2; B = 9'h1FD;
        while (c1 < TMO && !done) begin
            @(posedge clk); #1;
            c1++;
        end
        s1 = S;
        start = 1'b0;
        while (c2 < TMO) begin
            @(posedge clk); #1;
            c2++;
            if (done) break;
        end
        s2 = S;
        n_checks++;
        if (s1 !== 18'd16 || c1 != N + 1) begin
            n_fail++;
            $display("FAIL b2b_first: S=%h lat=%0d required %h %0d", s1, c1, 18'd16, N + 1);
        end
        n_checks++;
        if (s2 !== 18'h3FFFA || c2 != N + 1) begin
            n_fail++;
            $display("FAIL b2b_second: S=%h gap=%0d required %h %0d", s2, c2, 18'h3FFFA, N + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int ndone = 0;
        start = 1'b1; tc = 1'b0; A = 9'd100; B = 9'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== '0) begin
            n_fail++;
            $display("FAIL abort: busy=%b done=%b S=%h required 0 0 0", busy, done, S);
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * (N + 1); c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        n_checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: dones=%0d busy=%b required 0 0", ndone, busy);
        end
    endtask

    task automatic test_random();
        logic [2*W-1:0] s, e;
        int lat;
        logic b0, t;
        logic [W-1:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            t = $urandom_range(0, 1);
            a = W'($urandom);
            b = W'($urandom);
            e = ref_prod(t, a, b);
            do_op(t, a, b, s, lat, b0);
            n_checks++;
            if (s !== e || lat != N + 1) begin
                n_fail++;
                $display("FAIL random_%0d: tc=%b A=%h B=%h S=%h lat=%0d required %h %0d",
                         i, t, a, b, s, lat, e, N + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Iterative Booth multiplier that produces a full-width product of two `width`-bit operands over multiple clock cycles. It uses a start/done handshake and supports runtime signed or unsigned operand mode. It replaces the single-cycle 9-bit Booth/CLA multiplier in datapaths where area matters more than latency. An accumulate-and-shift core does one Booth step per cycle; radix-2 is the default and radix-4 is selectable at compile time.

## Interface
- `width`, default 9: operand width in bits; legal range 4..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply; sampled only when not busy.
- `tc`  in  1  operand mode: 1 = two's-complement signed, 0 = unsigned; latched with `start`.
- `A`  in  `width`  multiplicand; latched with `start`.
- `B`  in  `width`  multiplier; latched with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `S` is valid from this cycle.
- `S`  out  2*`width`  product; held until the next `done`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if `start`=1, do the following and go to RUN:
  - latch `A`, `B` and `tc`;
  - extend both operands to `width`+1 bits (sign-extend if `tc`=1, zero-extend if `tc`=0);
  - clear the accumulator and the Booth bit q(-1);
  - load the iteration counter with N.
- RUN: one Booth step per cycle.
  - Radix-2: examine {q0, q(-1)}:
    - 01 → add M;
    - 10 → subtract M;
    - 00 or 11 → no add;
    - then arithmetic-shift {acc, Q, q(-1)} right by 1.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- DONE: register the low 2*`width` bits of the extended product into `S`, pulse `done`, then:
  - if `start`=1 in this same cycle, accept new operands and go to RUN (back-to-back);
  - otherwise go to IDLE.
- Arithmetic: the internal accumulator is `width`+2 bits, so the radix-4 ±2M term cannot overflow.
  - The product is exact in both modes: signed range fits 2*`width` bits; unsigned (2^`width`−1)^2 fits 2*`width` bits.
- `start` while in RUN is ignored; operands present then are not latched.
- `tc`, `A` and `B` may change freely after the sampling edge.

## Timing
- Reset values: `busy`=0, `done`=0, `S`=0, state IDLE, accumulator and counter 0.
- Radix-2: N = `width`+1 iterations (10 for `width`=9).
- Edge numbering: edge 0 is the edge that samples `start`=1.
  - After edge 0: `busy`=1.
  - Edges 1..N: the N iterations.
  - After edge N+1: `done`=1, `busy`=0, `S` updated.
- Latency from `start` to `done` is N+1 cycles; throughput is one result per N+1 cycles when back-to-back.
- `done` is high for exactly one cycle unless another operation completes immediately after.
- `rst` during RUN or DONE aborts the operation: all outputs return to reset values on that edge, and no `done` is produced for the aborted operation.
- `rst` and `start` high together: `rst` wins, nothing is latched.

## Configuration
- `BOOTH_RADIX4_EN` defined: radix-4 (modified Booth) recoding.
  - Each step examines {q1, q0, q(-1)} and selects 0, ±M or ±2M, then shifts by 2.
  - The extended multiplier is padded to an even length, so N = ceil((`width`+1)/2) (5 for `width`=9).
  - Handshake, latency formula (N+1) and results are otherwise identical.
- Undefined: radix-2 as described in Operation.

## Test plan
- `tc`=1, `A`=9'h100 (−256), `B`=9'h100 → `S`=18'h10000 (65536), `done` exactly N+1 cycles after `start`.
- `tc`=1, `A`=9'h100 (−256), `B`=9'h0FF (255) → `S`=18'h30100 (−65280).
- `tc`=0, `A`=9'h1FF, `B`=9'h1FF → `S`=18'h3FC01 (261121); the same operands with `tc`=1 → `S`=18'h00001.
- Start `A`=3, `B`=5; pulse `start` with `A`=7, `B`=7 during RUN → `S`=15, a single `done`, no second result.
- Back-to-back: `start` held high through DONE with `A`=2, `B`=−3 (`tc`=1) after 4×4 → first `S`=16, second `S`=18'h3FFFA, second `done` N+1 cycles after the first.
- Assert `rst` mid-RUN → `busy`=0, `S`=0, no `done`; then run 1000 random operands in both modes against a golden product, in both macro builds.
